// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity selectors and frame-length helper
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic int frame_cycles(input int clks, input int data,
                                        input int parity, input int stop);
        return clks * (1 + data + ((parity != PARITY_NONE) ? 1 : 0) + stop);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter; tick marks the last cycle of each bit
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = 1'b0;
        cnt_d  = cnt_q;
        if (restart_i) begin
            cnt_d = CNT_MAX;
        end else if (cnt_q == '0) begin
            tick_o = 1'b1;
            cnt_d  = CNT_MAX;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - configurable UART transmitter with one-word holding register
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int IDX_W      = $clog2(DATA_BITS);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 load;
    logic                 accept;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (i_Clock),
        .rst_i    (i_Reset),
        .restart_i(state_q == ST_IDLE),
        .tick_o   (tick)
    );

    assign accept = i_Tx_DV && !hold_valid_q;

    // bit_idx counts data bits in DATA and stop bits in STOP
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        load      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_valid_q) load = 1'b1;
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                        if (hold_valid_q) load = 1'b1;
                        else              state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d   = ST_START;
            shift_d   = hold_q;
            parity_d  = (PARITY == PARITY_ODD) ? ~^hold_q : ^hold_q;
            bit_idx_d = '0;
        end
    end

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (load) hold_valid_d = 1'b0;
        if (accept) begin
            hold_d       = i_Tx_Byte;
            hold_valid_d = 1'b1;
        end
    end

    // Line value is decoded from next state so the pin flop changes on the bit edge itself
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = shift_d[0];
            ST_PARITY: serial_d = parity_d;
            default:   serial_d = 1'b1;
        endcase
        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_idx_q    <= '0;
            serial_q     <= 1'b1;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            bit_idx_q    <= bit_idx_d;
            serial_q     <= serial_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    assign o_Tx_Ready  = !hold_valid_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed bench for 8N1, 8E1, 8O1 and 7N2 transmitter instances
module tb_uart_tx_param;

    logic       clk;
    logic       rst;
    logic [3:0] dv;
    logic [7:0] din [4];
    logic [3:0] ser, act, done, rdy;
    logic [31:0] seq;
    int n_tests;
    int n_fail;

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[0]),
        .o_Tx_Ready(rdy[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(done[0]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[1]),
        .o_Tx_Ready(rdy[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(done[1]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[2]),
        .o_Tx_Ready(rdy[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(done[2]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(din[3][6:0]),
        .o_Tx_Ready(rdy[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Leaves the caller at the negedge of the first start-bit cycle
    task automatic start_word(input int u, input logic [7:0] b);
        din[u] = b;
        dv[u]  = 1'b1;
        @(negedge clk);
        dv[u] = 1'b0;
        check_eq($sformatf("u%0d lat_idle_serial", u), 32'(ser[u]), 32'd1);
        check_eq($sformatf("u%0d lat_ready", u), 32'(rdy[u]), 32'd0);
        @(negedge clk);
    endtask

    // Symbol i of exp is the line level for frame cycles 4*i..4*i+3; ends one cycle after the done pulse
    task automatic run_frame(input int u, input logic [31:0] exp, input int nsym,
                             input int q_at, input logic [7:0] q_byte);
        for (int c = 0; c < nsym * 4; c++) begin
            check_eq($sformatf("u%0d serial c%0d", u, c), 32'(ser[u]), 32'(exp[c / 4]));
            check_eq($sformatf("u%0d active c%0d", u, c), 32'(act[u]), 32'd1);
            check_eq($sformatf("u%0d done c%0d", u, c), 32'(done[u]), 32'd0);
            if (c == q_at) begin
                din[u] = q_byte;
                dv[u]  = 1'b1;
            end
            if (c == q_at + 1) dv[u] = 1'b0;
            @(negedge clk);
        end
        dv[u] = 1'b0;
        check_eq($sformatf("u%0d done_pulse", u), 32'(done[u]), 32'd1);
        check_eq($sformatf("u%0d active_end", u), 32'(act[u]), 32'd0);
        check_eq($sformatf("u%0d serial_end", u), 32'(ser[u]), 32'd1);
        @(negedge clk);
        check_eq($sformatf("u%0d done_once", u), 32'(done[u]), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        dv  = '0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check_eq($sformatf("u%0d rst_serial", u), 32'(ser[u]), 32'd1);
            check_eq($sformatf("u%0d rst_ready", u), 32'(rdy[u]), 32'd1);
            check_eq($sformatf("u%0d rst_active", u), 32'(act[u]), 32'd0);
            check_eq($sformatf("u%0d rst_done", u), 32'(done[u]), 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0xA5: start, 1,0,1,0,0,1,0,1, stop
        start_word(0, 8'hA5);
        run_frame(0, 32'b1101001010, 10, -1, 8'h00);
        // 8E1 0xA5: four ones, parity 0
        start_word(1, 8'hA5);
        run_frame(1, 32'b10101001010, 11, -1, 8'h00);
        // 8O1 0xA5: parity 1
        start_word(2, 8'hA5);
        run_frame(2, 32'b11101001010, 11, -1, 8'h00);
        // 7N2 0x55: seven data bits then two stop bits
        start_word(3, 8'h55);
        run_frame(3, 32'b1110101010, 10, -1, 8'h00);
        repeat (2) @(negedge clk);

        // Back-to-back 0x01 then 0x80 with zero gap
        seq = {12'h000, 10'b1100000000, 10'b1000000010};
        start_word(0, 8'h01);
        for (int c = 0; c < 82; c++) begin
            check_eq($sformatf("b2b serial c%0d", c), 32'(ser[0]), (c < 80) ? 32'(seq[c / 4]) : 32'd1);
            check_eq($sformatf("b2b ready c%0d", c), 32'(rdy[0]), (c >= 6 && c <= 39) ? 32'd0 : 32'd1);
            check_eq($sformatf("b2b active c%0d", c), 32'(act[0]), (c < 80) ? 32'd1 : 32'd0);
            check_eq($sformatf("b2b done c%0d", c), 32'(done[0]), (c == 40 || c == 80) ? 32'd1 : 32'd0);
            if (c == 5) begin
                din[0] = 8'h80;
                dv[0]  = 1'b1;
            end
            if (c == 6) dv[0] = 1'b0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // DV held high with a changing byte: only C0, C2 and EA are accepted
        seq = {2'b00, 10'b1111010100, 10'b1110000100, 10'b1110000000};
        for (int k = 0; k < 124; k++) begin
            check_eq($sformatf("hold serial k%0d", k), 32'(ser[0]),
                     (k >= 2 && k < 122) ? 32'(seq[(k - 2) / 4]) : 32'd1);
            check_eq($sformatf("hold ready k%0d", k), 32'(rdy[0]),
                     (k == 0 || k == 2 || k == 42 || k >= 82) ? 32'd1 : 32'd0);
            check_eq($sformatf("hold done k%0d", k), 32'(done[0]),
                     (k == 42 || k == 82 || k == 122) ? 32'd1 : 32'd0);
            dv[0]  = (k <= 42);
            din[0] = 8'(8'hC0 + k[7:0]);
            @(negedge clk);
        end
        dv[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Accept in the last stop cycle with holding empty: one idle cycle, then 0xF0
        start_word(0, 8'h0F);
        run_frame(0, 32'b1000011110, 10, 39, 8'hF0);
        run_frame(0, 32'b1111100000, 10, -1, 8'h00);
        repeat (2) @(negedge clk);

        // Reset at frame cycle 17 with a word queued
        start_word(0, 8'h3C);
        for (int c = 0; c < 18; c++) begin
            if (c == 2) check_eq("rst_mid queued", 32'(rdy[0]), 32'd0);
            if (c == 1) begin
                din[0] = 8'h99;
                dv[0]  = 1'b1;
            end
            if (c == 2) dv[0] = 1'b0;
            if (c == 17) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        check_eq("rst_mid serial", 32'(ser[0]), 32'd1);
        check_eq("rst_mid ready", 32'(rdy[0]), 32'd1);
        check_eq("rst_mid active", 32'(act[0]), 32'd0);
        check_eq("rst_mid done", 32'(done[0]), 32'd0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst_after serial c%0d", c), 32'(ser[0]), 32'd1);
            check_eq($sformatf("rst_after done c%0d", c), 32'(done[0]), 32'd0);
            check_eq($sformatf("rst_after active c%0d", c), 32'(act[0]), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It serialises 5–9 data bits LSB-first, with an optional odd/even parity bit and 1 or 2 stop bits.
- A one-entry holding register plus a ready/valid handshake lets the host queue the next word while a frame is in flight. Back-to-back frames go out with zero idle gap.
- It sits between the byte-producing logic (e.g. hash-result formatter) and the board TX pin.
- It replaces the fixed 8N1 transmitter wherever framing or throughput must be configurable.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (≥2); 100 MHz / 115200 baud.
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.

Ports:
- i_Clock  input  1  system clock, all logic on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Tx_DV  input  1  host word valid.
- i_Tx_Byte  input  DATA_BITS  host word; bit 0 is transmitted first.
- o_Tx_Ready  output  1  holding register empty; a word is accepted on the edge where i_Tx_DV && o_Tx_Ready.
- o_Tx_Active  output  1  high from the first start-bit cycle to the last stop-bit cycle of the frame.
- o_Tx_Serial  output  1  serial line, idle high.
- o_Tx_Done  output  1  one-cycle pulse after each frame's final stop-bit cycle.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. On i_Reset:
  - state=IDLE, holding register empty, counters cleared.
  - o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0.
- Reset mid-frame: the frame is aborted, the line is high on the cycle after the reset edge, and any queued word is discarded. No o_Tx_Done is issued.
- Handshake:
  - o_Tx_Ready is combinational from the holding-valid flag only, with no dependency on i_Tx_DV.
  - i_Tx_DV while o_Tx_Ready=0 is ignored; no word is captured.
  - Accepting a word sets the holding register. The shifter loads from the holding register, which frees it.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the holding register is valid. The word moves to the shifter and o_Tx_Ready rises the same edge.
  - Latency: a word accepted at edge N in IDLE drives o_Tx_Serial=0 after edge N+1. That cycle has holding valid; the load occurs at N+1.
  - START: drive 0 for CLKS_PER_BIT cycles → DATA.
  - DATA: drive shifter[bit_idx] for CLKS_PER_BIT cycles per bit. After bit DATA_BITS-1 → PARITY if PARITY≠0, else STOP.
  - PARITY: drive the parity bit for CLKS_PER_BIT cycles → STOP. Even = XOR of data bits; odd = its inverse.
  - STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, pulse o_Tx_Done. Then go → START directly, loading the holding register, if it is valid; otherwise → IDLE.
- Frame length is exactly CLKS_PER_BIT*(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles. There are no CLEANUP cycles and no idle gap between queued frames.
- Counters:
  - Bit counter width $clog2(CLKS_PER_BIT).
  - Stop counter covers 2*CLKS_PER_BIT.
  - bit_idx width $clog2(DATA_BITS).
  - All wrap to 0 at each bit boundary; no overflow beyond terminal count.
- Output registering: o_Tx_Serial is registered and glitch-free.
- Simultaneous events:
  - Accept on the same edge the shifter loads from the holding register: legal. The holding register ends valid with the new word.
  - Accept during STOP's last cycle while holding is empty: the word is written to holding, and the FSM loads it on the following edge (one-cycle line-high gap is acceptable only in this case).
- Parameter checks: illegal values trigger an elaboration-time $error.

Decomposition:
- Package uart_pkg holds:
  - state encoding constants (3 bits);
  - PARITY_NONE/ODD/EVEN constants;
  - function frame_cycles(clks, data, parity, stop) for benches.
- One natural sub-module, uart_bit_timer: a CLKS_PER_BIT down-counter with restart input and a tick output, reusable by the matching receiver.

Test Plan (benches use CLKS_PER_BIT=4):
- 8N1, send 0xA5 from IDLE: line is low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. o_Tx_Done pulses once 40 cycles after the start bit begins; o_Tx_Active is high exactly 40 cycles.
- PARITY=2 with 0xA5: parity bit=0, frame 44 cycles. PARITY=1 with the same word: parity bit=1.
- DATA_BITS=7, STOP_BITS=2, send 0x55: 7 data bits then 8 high cycles; frame 40 cycles.
- Back-to-back, 8N1: send 0x01, then 0x80 while o_Tx_Ready=1 mid-frame. o_Tx_Ready drops until the 0x80 load; the second start bit follows the first stop bit with zero gap; two o_Tx_Done pulses 40 cycles apart.
- i_Tx_DV held high with a changing byte while o_Tx_Ready=0: only the accepted words are transmitted, in order; no corruption.
- Assert i_Reset at cycle 17 of a frame: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0 on the next cycle; no o_Tx_Done; a queued word is dropped.
